// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the pipeline hazard/branch logic and fetch_ctrl.
// Optional stall/flush performance counters are present when FETCH_CTRL_PERF_EN is defined.
interface fetch_ctrl_if;
    logic        redirect;
    logic        ext_stall;
    logic        load_use;
    logic        predict_taken;
    logic [2:0]  pc_sel;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic [1:0]  state_o;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    // Pipeline side: raises stall/redirect requests and consumes fetch controls
    modport master (
        output redirect,
        output ext_stall,
        output load_use,
        output predict_taken,
        input  pc_sel,
        input  pc_en,
        input  ifid_en,
        input  ifid_flush,
        input  idex_flush,
        input  state_o
`ifdef FETCH_CTRL_PERF_EN
        ,
        input  stall_cnt,
        input  flush_cnt
`endif
    );

    // Controller side
    modport slave (
        input  redirect,
        input  ext_stall,
        input  load_use,
        input  predict_taken,
        output pc_sel,
        output pc_en,
        output ifid_en,
        output ifid_flush,
        output idex_flush,
        output state_o
`ifdef FETCH_CTRL_PERF_EN
        ,
        output stall_cnt,
        output flush_cnt
`endif
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Front-end fetch controller: BOOT/RUN/STALL/FLUSH sequencing with Mealy PC and IF/ID control.
// Define FETCH_CTRL_PERF_EN to add saturating stall_cnt / flush_cnt performance counters.
module fetch_ctrl #(
    parameter int BOOT_CYCLES  = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.slave  bus
);
    localparam int BOOT_W  = (BOOT_CYCLES  > 1) ? $clog2(BOOT_CYCLES)  : 1;
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [BOOT_W-1:0]  BOOT_LOAD  = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [BOOT_W-1:0]  BOOT_ZERO  = {BOOT_W{1'b0}};
    localparam logic [FLUSH_W-1:0] FLUSH_ZERO = {FLUSH_W{1'b0}};
    localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1'b1);

    localparam logic [2:0] SEL_SEQ  = 3'b000;
    localparam logic [2:0] SEL_BR   = 3'b001;
    localparam logic [2:0] SEL_PRED = 3'b010;
    localparam logic [2:0] SEL_RST  = 3'b100;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10,
        ST_FLUSH = 2'b11
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [BOOT_W-1:0]  boot_ctr_r;
    logic [BOOT_W-1:0]  boot_ctr_nxt_s;
    logic [FLUSH_W-1:0] flush_ctr_r;
    logic [FLUSH_W-1:0] flush_ctr_nxt_s;

    logic [2:0] pc_sel_s;
    logic       pc_en_s;
    logic       ifid_en_s;
    logic       ifid_flush_s;
    logic       idex_flush_s;

    // Next-state, down-counter and Mealy output decode
    always_comb begin
        state_nxt_s     = state_r;
        boot_ctr_nxt_s  = boot_ctr_r;
        flush_ctr_nxt_s = flush_ctr_r;
        pc_sel_s        = SEL_SEQ;
        pc_en_s         = 1'b1;
        ifid_en_s       = 1'b1;
        ifid_flush_s    = 1'b0;
        idex_flush_s    = 1'b0;

        if (rst) begin
            // Reset drives the boot vector regardless of the held state
            pc_sel_s     = SEL_RST;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    pc_sel_s     = SEL_RST;
                    ifid_flush_s = 1'b1;
                    idex_flush_s = 1'b1;
                    if (boot_ctr_r == BOOT_ZERO) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        boot_ctr_nxt_s = boot_ctr_r - BOOT_W'(1'b1);
                    end
                end
                ST_RUN, ST_STALL, ST_FLUSH: begin
                    if (bus.ext_stall) begin
                        // Freeze the whole front end; a pending flush keeps its count
                        pc_en_s     = 1'b0;
                        ifid_en_s   = 1'b0;
                        state_nxt_s = (state_r == ST_FLUSH) ? ST_FLUSH : ST_STALL;
                    end else if (bus.redirect) begin
                        pc_sel_s        = SEL_BR;
                        ifid_flush_s    = 1'b1;
                        idex_flush_s    = 1'b1;
                        flush_ctr_nxt_s = FLUSH_LOAD;
                        state_nxt_s     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                    end else if (state_r == ST_FLUSH) begin
                        ifid_flush_s = 1'b1;
                        if (flush_ctr_r > FLUSH_ONE) begin
                            flush_ctr_nxt_s = flush_ctr_r - FLUSH_ONE;
                        end else begin
                            flush_ctr_nxt_s = FLUSH_ZERO;
                            state_nxt_s     = ST_RUN;
                        end
                    end else if (bus.load_use) begin
                        pc_en_s      = 1'b0;
                        ifid_en_s    = 1'b0;
                        idex_flush_s = 1'b1;
                        state_nxt_s  = ST_RUN;
                    end else if (bus.predict_taken) begin
                        pc_sel_s    = SEL_PRED;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    state_nxt_s     = ST_BOOT;
                    boot_ctr_nxt_s  = BOOT_LOAD;
                    flush_ctr_nxt_s = FLUSH_ZERO;
                end
            endcase
        end
    end

    // State register and BOOT/FLUSH down-counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_BOOT;
            boot_ctr_r  <= BOOT_LOAD;
            flush_ctr_r <= FLUSH_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            boot_ctr_r  <= boot_ctr_nxt_s;
            flush_ctr_r <= flush_ctr_nxt_s;
        end
    end

    assign bus.pc_sel     = pc_sel_s;
    assign bus.pc_en      = pc_en_s;
    assign bus.ifid_en    = ifid_en_s;
    assign bus.ifid_flush = ifid_flush_s;
    assign bus.idex_flush = idex_flush_s;
    assign bus.state_o    = state_r;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;
    logic        live_s;

    assign live_s = (!rst) && (state_r != ST_BOOT);

    // Saturating stall and flush occupancy counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_r <= 32'h0000_0000;
            perf_flush_r <= 32'h0000_0000;
        end else begin
            if (live_s && !pc_en_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
            if (live_s && ifid_flush_s && (perf_flush_r != 32'hFFFF_FFFF)) begin
                perf_flush_r <= perf_flush_r + 32'd1;
            end else begin
                perf_flush_r <= perf_flush_r;
            end
        end
    end

    assign bus.stall_cnt = perf_stall_r;
    assign bus.flush_cnt = perf_flush_r;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter BOOT_CYCLES, default 1, min 1: cycles spent in BOOT after reset release.
REQ-002 Parameter FLUSH_CYCLES, default 1, min 1: total IF/ID flush cycles per redirect.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 redirect  in  1  EX-resolved mispredict; fetch branch target.
REQ-006 ext_stall  in  1  memory-side stall; freeze whole front end.
REQ-007 load_use  in  1  hazard-unit load-use stall request.
REQ-008 predict_taken  in  1  predictor hit in IF; fetch predicted target.
REQ-009 pc_sel  out  3  PC mux select: 000 PC+4, 001 branch, 010 predicted_target, 100 reset vector.
REQ-010 pc_en  out  1  PC register enable.
REQ-011 ifid_en  out  1  IF/ID register enable (IFIDWRITE).
REQ-012 ifid_flush  out  1  IF/ID contents replaced by NOP/bubble at next edge.
REQ-013 idex_flush  out  1  bubble inserted into ID/EX at next edge.
REQ-014 state_o  out  2  current state: 00 BOOT, 01 RUN, 10 STALL, 11 FLUSH.

Function
REQ-015 State register plus BOOT and FLUSH down-counters SHALL be the only state; outputs SHALL be combinational (Mealy) from state and inputs.
REQ-016 BOOT: pc_sel=100, pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; all inputs ignored; after BOOT_CYCLES cycles -> RUN.
REQ-017 RUN/STALL priority SHALL be ext_stall > redirect > load_use > predict_taken > sequential.
REQ-018 ext_stall=1: pc_en=0, ifid_en=0, both flushes 0, pc_sel=000; next state STALL; STALL holds while ext_stall=1, exits to RUN when it drops, with remaining inputs evaluated as in RUN that same cycle.
REQ-019 redirect=1 (no ext_stall): pc_sel=001, pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; next state FLUSH with counter loaded FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES=1.
REQ-020 FLUSH: pc_sel=000, pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=0; counter decrements each cycle, -> RUN at zero; load_use and predict_taken ignored.
REQ-021 redirect during FLUSH SHALL reload the counter and apply REQ-019 outputs; ext_stall during FLUSH SHALL freeze outputs per REQ-018 and hold the counter, staying in FLUSH.
REQ-022 load_use=1 (no ext_stall, no redirect): pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; stays RUN; stalls every cycle it is asserted.
REQ-023 predict_taken=1 alone: pc_sel=010, pc_en=1, ifid_en=1, flushes 0.
REQ-024 No inputs: pc_sel=000, pc_en=1, ifid_en=1, flushes 0.
REQ-025 ifid_en=0 and ifid_flush=1 SHALL never be asserted together.

Reset
REQ-026 rst=1 at a rising edge SHALL force state BOOT, BOOT counter=BOOT_CYCLES-1, FLUSH counter=0, from any state including mid-FLUSH or STALL.
REQ-027 While rst=1 outputs SHALL equal BOOT outputs (REQ-016).

Configuration
REQ-028 Macro FETCH_CTRL_PERF_EN defined: adds outputs stall_cnt (32, cycles with pc_en=0 in RUN/STALL/FLUSH) and flush_cnt (32, cycles with ifid_flush=1 outside BOOT), both saturating at 0xFFFFFFFF, cleared by rst.
REQ-029 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 rst=1 for 2 cycles, BOOT_CYCLES=2, then release -> state_o 00 for 2 cycles with pc_sel=100, then 01 with pc_sel=000, pc_en=1.
REQ-031 RUN, redirect pulse 1 cycle, FLUSH_CYCLES=3 -> that cycle pc_sel=001, ifid_flush=1, idex_flush=1; next 2 cycles state 11, ifid_flush=1, pc_sel=000; then state 01.
REQ-032 RUN, load_use high 1 cycle with predict_taken=1 -> pc_en=0, ifid_en=0, idex_flush=1, pc_sel≠010; next cycle with predict_taken=1 -> pc_sel=010, pc_en=1.
REQ-033 ext_stall and redirect both high 3 cycles, then ext_stall low -> 3 cycles pc_en=0, ifid_en=0, state 10, no flush; 4th cycle pc_sel=001, ifid_flush=1.
REQ-034 rst asserted during FLUSH count 2 -> next cycle state 00, BOOT outputs; with FETCH_CTRL_PERF_EN, stall_cnt=0 and flush_cnt=0.
REQ-035 FETCH_CTRL_PERF_EN, 5 load_use cycles and one redirect, FLUSH_CYCLES=2 -> stall_cnt=5, flush_cnt=2.
